// File: rtl/cheshire_uart_pkg.sv
// Shared definitions for the Cheshire UART receive path.
//   uart_state_e    : receiver FSM states
//   UartDataBits    : payload bits per frame (8N1)
//   UartDefaultDiv  : clocks per bit for the fixture's default clock and baud
//   clamp_div()     : enforces a lower bound on the clocks-per-bit divider
package cheshire_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned UartDataBits     = 8;
   localparam int unsigned UartDefaultClkHz = 50_000_000;
   localparam int unsigned UartDefaultBaud  = 115_200;
   localparam logic [15:0] UartDefaultDiv   = 16'(UartDefaultClkHz / UartDefaultBaud);

   function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] min_div);
      return (div < min_div) ? min_div : div;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO, port-compatible subset of common_cells fifo_v3.
//   clk_i   : clock
//   flush_i : synchronous clear, empties the FIFO
//   full_o  : no free slot
//   empty_o : nothing stored
//   data_i  : write data, push_i : write request
//   data_o  : head entry, pop_i : read request
// With FALL_THROUGH=0 the head entry is presented on data_o as soon as it is
// stored (one cycle after the push). A push into a full FIFO succeeds when a
// pop happens in the same cycle, since the pop frees the slot.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH        = 4
) (
   input  logic                  clk_i,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [AW:0]           count;
   logic                  bypass;
   logic                  do_pop;
   logic                  do_push;

   assign full_o  = (count == (AW+1)'(DEPTH));
   assign empty_o = (count == '0);

   // In fall-through mode an empty FIFO hands data_i straight to the reader.
   assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop) && !bypass;
   assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cheshire_uart_byte_rx.sv
// 8N1 UART receiver with a small byte buffer on a valid/ready output stream.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clk_div_i    : clocks per bit, captured at each start bit (clamped to MinDiv)
//   rx_i         : asynchronous serial line, idles high
//   data_o       : head byte of the buffer (0 when empty)
//   valid_o      : data_o holds a byte
//   ready_i      : consumer accepts the byte when valid_o && ready_i
//   frame_err_o  : one-cycle pulse when a stop bit is sampled low
//   overflow_o   : sticky, set when a received byte is dropped on a full buffer
//   clr_i        : clears overflow_o (a same-cycle new overflow wins)
//   busy_o       : receiver FSM is not idle
// Stream handshake: a byte transfers on every rising clk_i edge where
// valid_o && ready_i; valid_o is a pure function of the buffer state and never
// of ready_i, and data_o/valid_o hold while valid_o && !ready_i.
module cheshire_uart_byte_rx
   import cheshire_uart_pkg::*;
#(
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned MinDiv    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] clk_div_i,
   input  logic        rx_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        frame_err_o,
   output logic        overflow_o,
   input  logic        clr_i,
   output logic        busy_o
);

   localparam logic [15:0] MinDivW = 16'(MinDiv);

   uart_state_e             state_q;
   logic                    rx_m;
   logic                    rx_s;
   logic                    rx_q;
   logic [15:0]             div_q;
   logic [15:0]             cnt_q;
   logic [2:0]              idx_q;
   logic [UartDataBits-1:0] sh_q;
   logic                    frame_err_q;
   logic                    overflow_q;

   logic                    hit_half;
   logic                    hit_bit;
   logic                    push;
   logic                    pop;
   logic                    drop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [UartDataBits-1:0] fifo_data;

   // Mid-start-bit check and full-bit sample points, relative to cnt_q.
   assign hit_half = (cnt_q == ((div_q >> 1) - 16'd1));
   assign hit_bit  = (cnt_q == (div_q - 16'd1));

   // The push fires on the stop-bit sample edge itself so the byte becomes
   // visible in the same cycle as a frame error would have been.
   assign push = (state_q == STOP) && hit_bit && rx_s;
   assign pop  = valid_o && ready_i;
   assign drop = push && fifo_full && !pop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         rx_q        <= 1'b1;
         state_q     <= IDLE;
         div_q       <= MinDivW;
         cnt_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rx_m        <= rx_i;
         rx_s        <= rx_m;
         rx_q        <= rx_s;
         frame_err_q <= 1'b0;

         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clr_i) begin
            overflow_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               // Only a high-to-low edge starts a frame, so a held-low
               // break line does not retrigger.
               if (rx_q && !rx_s) begin
                  div_q   <= clamp_div(clk_div_i, MinDivW);
                  cnt_q   <= '0;
                  state_q <= START;
               end
            end
            START: begin
               if (hit_half) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  state_q <= rx_s ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (hit_bit) begin
                  sh_q[idx_q] <= rx_s;
                  idx_q       <= idx_q + 3'd1;
                  cnt_q       <= '0;
                  if (idx_q == 3'(UartDataBits - 1)) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (hit_bit) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  if (!rx_s) begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (UartDataBits),
      .DEPTH        (FifoDepth)
   ) i_fifo (
      .clk_i   (clk_i),
      .flush_i (rst_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (sh_q),
      .push_i  (push),
      .data_o  (fifo_data),
      .pop_i   (pop)
   );

   assign valid_o     = !fifo_empty;
   assign data_o      = valid_o ? fifo_data : '0;
   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_cheshire_uart_byte_rx.sv
// Directed bench for cheshire_uart_byte_rx: serial frames are driven on rx_i,
// accepted bytes are checked against an expected queue, and frame timing is
// checked against hand-computed cycle offsets.
module tb_cheshire_uart_byte_rx;

   logic        clk_i;
   logic        rst_i;
   logic [15:0] clk_div_i;
   logic        rx_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        frame_err_o;
   logic        overflow_o;
   logic        clr_i;
   logic        busy_o;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          t0 = 0;
   int          rise_cyc = -1;
   int          fe_cnt = 0;
   int          fe_cyc = -1;
   int          acc_cnt = 0;
   int          fe0 = 0;
   int          acc0 = 0;
   logic        valid_prev = 1'b0;
   logic        busy_seen = 1'b0;
   logic [7:0]  exp_q[$];

   cheshire_uart_byte_rx #(
      .FifoDepth (4),
      .MinDiv    (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clk_div_i   (clk_div_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overflow_o  (overflow_o),
      .clr_i       (clr_i),
      .busy_o      (busy_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called on a negedge; drives start, 8 data bits LSB first, stop, each
   // held for div clocks. nbits < 10 truncates the frame.
   task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit, input int nbits);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      t0 = cyc;
      for (int j = 0; j < nbits; j++) begin
         rx_i = fr[j];
         repeat (div) @(negedge clk_i);
      end
      rx_i = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_i) begin
      #1;
      if (valid_o && !valid_prev) rise_cyc = cyc;
      valid_prev = valid_o;
      if (frame_err_o) begin
         fe_cnt++;
         fe_cyc = cyc;
      end
      if (busy_o) busy_seen = 1'b1;
      if (valid_o && ready_i) begin
         acc_cnt++;
         check("accept_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("accept_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_i     = 1'b1;
      clk_div_i = 16'd16;
      rx_i      = 1'b1;
      ready_i   = 1'b0;
      clr_i     = 1'b0;
      repeat (3) @(negedge clk_i);

      // reset values
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'h00);
      check("rst_frame_err", 32'(frame_err_o), 32'd0);
      check("rst_overflow", 32'(overflow_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      repeat (4) @(negedge clk_i);

      // single frame 0x55 at 16 clk/bit: valid rises 3 + 8 + 9*16 = 155 cycles after start
      fe0 = fe_cnt;
      busy_seen = 1'b0;
      send_frame(8'h55, 16, 1'b1, 10);
      check("single_rise_cycle", 32'(rise_cyc - t0), 32'd155);
      check("single_valid", 32'(valid_o), 32'd1);
      check("single_data", 32'(data_o), 32'h55);
      check("single_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      check("single_busy_seen", 32'(busy_seen), 32'd1);
      repeat (3) @(negedge clk_i);
      check("single_hold_data", 32'(data_o), 32'h55);
      exp_q.push_back(8'h55);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      @(negedge clk_i);
      check("single_drained", 32'(valid_o), 32'd0);

      // back-to-back 0x00, 0xFF, 0xA5 at 8 clk/bit
      clk_div_i = 16'd8;
      ready_i = 1'b1;
      acc0 = acc_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hA5);
      send_frame(8'h00, 8, 1'b1, 10);
      send_frame(8'hFF, 8, 1'b1, 10);
      send_frame(8'hA5, 8, 1'b1, 10);
      repeat (8) @(negedge clk_i);
      check("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
      check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
      check("b2b_overflow", 32'(overflow_o), 32'd0);
      check("b2b_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

      // framing error: 0x3C with stop bit low, then a good 0x81
      clk_div_i = 16'd16;
      fe0 = fe_cnt;
      acc0 = acc_cnt;
      send_frame(8'h3C, 16, 1'b0, 10);
      repeat (16) @(negedge clk_i);
      check("ferr_pulse_count", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_pulse_cycle", 32'(fe_cyc - t0), 32'd155);
      check("ferr_no_push", 32'(acc_cnt - acc0), 32'd0);
      check("ferr_valid", 32'(valid_o), 32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 16, 1'b1, 10);
      repeat (8) @(negedge clk_i);
      check("ferr_next_accept", 32'(acc_cnt - acc0), 32'd1);
      check("ferr_next_queue", 32'(exp_q.size()), 32'd0);

      // glitch: 3-cycle low pulse at 16 clk/bit
      ready_i = 1'b0;
      fe0 = fe_cnt;
      busy_seen = 1'b0;
      rx_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (40) @(negedge clk_i);
      check("glitch_started", 32'(busy_seen), 32'd1);
      check("glitch_idle", 32'(busy_o), 32'd0);
      check("glitch_valid", 32'(valid_o), 32'd0);
      check("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);

      // overflow: 5 bytes into a 4-deep buffer with ready low
      clk_div_i = 16'd8;
      send_frame(8'h01, 8, 1'b1, 10);
      send_frame(8'h02, 8, 1'b1, 10);
      send_frame(8'h03, 8, 1'b1, 10);
      send_frame(8'h04, 8, 1'b1, 10);
      repeat (4) @(negedge clk_i);
      check("ovf_full_no_ovf", 32'(overflow_o), 32'd0);
      check("ovf_full_head", 32'(data_o), 32'h01);
      send_frame(8'h05, 8, 1'b1, 10);
      repeat (4) @(negedge clk_i);
      check("ovf_set", 32'(overflow_o), 32'd1);
      check("ovf_head_stable", 32'(data_o), 32'h01);
      acc0 = acc_cnt;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      ready_i = 1'b1;
      repeat (6) @(negedge clk_i);
      ready_i = 1'b0;
      check("ovf_drain_count", 32'(acc_cnt - acc0), 32'd4);
      check("ovf_drain_empty", 32'(valid_o), 32'd0);
      check("ovf_sticky", 32'(overflow_o), 32'd1);
      clr_i = 1'b1;
      @(negedge clk_i);
      clr_i = 1'b0;
      @(negedge clk_i);
      check("ovf_cleared", 32'(overflow_o), 32'd0);

      // reset mid-frame with a byte already buffered
      clk_div_i = 16'd16;
      send_frame(8'h11, 16, 1'b1, 10);
      repeat (4) @(negedge clk_i);
      check("midrst_preload", 32'(valid_o), 32'd1);
      send_frame(8'h77, 16, 1'b1, 5);
      check("midrst_busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      rx_i  = 1'b1;
      @(negedge clk_i);
      check("midrst_valid", 32'(valid_o), 32'd0);
      check("midrst_data", 32'(data_o), 32'h00);
      check("midrst_busy_off", 32'(busy_o), 32'd0);
      check("midrst_frame_err", 32'(frame_err_o), 32'd0);
      check("midrst_overflow", 32'(overflow_o), 32'd0);
      rst_i = 1'b0;
      repeat (200) @(negedge clk_i);
      check("midrst_no_byte", 32'(valid_o), 32'd0);

      // clamp: divider 2 is raised to 4; valid rises 3 + 2 + 9*4 = 41 cycles after start
      clk_div_i = 16'd2;
      send_frame(8'h9C, 4, 1'b1, 10);
      repeat (8) @(negedge clk_i);
      check("clamp_rise_cycle", 32'(rise_cyc - t0), 32'd41);
      check("clamp_valid", 32'(valid_o), 32'd1);
      check("clamp_data", 32'(data_o), 32'h9C);
      exp_q.push_back(8'h9C);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_valid", 32'(valid_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
